// File: rtl/game_pkg.sv
// ============================================================================
//  Module      : game_pkg
//  Description : Shared screen geometry, pixel field widths, colour constants
//                and blitter FSM state encoding for the game datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] TRANSPARENT  = 3'b000;

    // Blitter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_scan_counter.sv
// ============================================================================
//  Module      : sprite_scan_counter
//  Description : Row-major dx/dy scan counter over an SPR_W x SPR_H box with
//                clear, enable and a flag marking the last texel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_scan_counter
    import game_pkg::*;
#(
    parameter int SPR_W = 20,
    parameter int SPR_H = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_en,
    output logic [cnt_w(SPR_W)-1:0]   o_dx,
    output logic [cnt_w(SPR_H)-1:0]   o_dy,
    output logic                      o_last
);

    localparam int DX_W = cnt_w(SPR_W);
    localparam int DY_W = cnt_w(SPR_H);
    localparam logic [DX_W-1:0] c_DX_MAX = DX_W'(SPR_W - 1);
    localparam logic [DY_W-1:0] c_DY_MAX = DY_W'(SPR_H - 1);

    logic [DX_W-1:0] r_dx;
    logic [DY_W-1:0] r_dy;
    logic            w_dx_wrap;

    assign w_dx_wrap = (r_dx == c_DX_MAX);

    // Advance across a row, wrapping dx and stepping dy at the row end
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_en) begin
            if (w_dx_wrap) begin
                r_dx <= '0;
                r_dy <= (r_dy == c_DY_MAX) ? '0 : r_dy + DY_W'(1);
            end else begin
                r_dx <= r_dx + DX_W'(1);
            end
        end
    end

    assign o_dx   = r_dx;
    assign o_dy   = r_dy;
    assign o_last = w_dx_wrap && (r_dy == c_DY_MAX);

endmodule

`default_nettype wire

// File: rtl/sprite_blitter.sv
// ============================================================================
//  Module      : sprite_blitter
//  Description : Rasterises one rectangular sprite per request into a pixel
//                stream, reading a 1-cycle synchronous ROM, clipping pixels
//                beyond the screen and skipping transparent texels. Blank
//                mode paints the whole on-screen box black.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_blitter
    import game_pkg::*;
#(
    parameter int                    SPR_W       = 20,
    parameter int                    SPR_H       = 20,
    parameter int                    ADDR_W      = 9,
    parameter int                    SCREEN_W    = game_pkg::SCREEN_W,
    parameter int                    SCREEN_H    = game_pkg::SCREEN_H,
    parameter logic [COLOUR_W-1:0]   TRANSPARENT = game_pkg::TRANSPARENT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  blank,
    input  logic [X_W-1:0]        x_init,
    input  logic [Y_W-1:0]        y_init,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [COLOUR_W-1:0]   rom_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pix_valid,
    output logic [X_W-1:0]        pix_x,
    output logic [Y_W-1:0]        pix_y,
    output logic [COLOUR_W-1:0]   pix_colour
);

    localparam int DX_W = cnt_w(SPR_W);
    localparam int DY_W = cnt_w(SPR_H);
    // Clip bounds at the one-bit-wider width so x_init+dx cannot wrap on-screen
    localparam logic [X_W:0] c_SCREEN_W_WIDE = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] c_SCREEN_H_WIDE = (Y_W+1)'(SCREEN_H);

    logic [1:0]          r_state;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic                r_blank;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_pv;
    logic [X_W:0]        r_px;
    logic [Y_W:0]        r_py;

    logic [DX_W-1:0]     w_dx;
    logic [DY_W-1:0]     w_dy;
    logic                w_last;
    logic                w_start;
    logic                w_run;
    logic                w_on_screen;
    logic                w_opaque;

    assign w_start = (r_state == ST_IDLE) && start;
    assign w_run   = (r_state == ST_RUN);

    sprite_scan_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_scan (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_start),
        .i_en    (w_run),
        .o_dx    (w_dx),
        .o_dy    (w_dy),
        .o_last  (w_last)
    );

    // Control FSM: latch request, walk the ROM address, drain the pipe, pulse done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_blank    <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_x0       <= x_init;
                        r_y0       <= y_init;
                        r_blank    <= blank;
                        r_rom_addr <= '0;
                    end
                end
                ST_RUN: begin
                    // Address is row-major, so it simply tracks the scan counter linearly
                    if (w_last) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                end
                ST_FLUSH: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Pixel-coordinate pipe stage aligned with the ROM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pv <= 1'b0;
            r_px <= '0;
            r_py <= '0;
        end else begin
            r_pv <= w_run;
            if (w_run) begin
                r_px <= (X_W+1)'(r_x0) + (X_W+1)'(w_dx);
                r_py <= (Y_W+1)'(r_y0) + (Y_W+1)'(w_dy);
            end
        end
    end

    // Clip and transparency qualification against the texel arriving this cycle
    always_comb begin
        w_on_screen = (r_px < c_SCREEN_W_WIDE) && (r_py < c_SCREEN_H_WIDE);
        w_opaque    = r_blank || (rom_data != TRANSPARENT);
    end

    assign rom_addr   = r_rom_addr;
    assign busy       = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign done       = (r_state == ST_DONE);
    assign pix_valid  = r_pv && w_on_screen && w_opaque;
    assign pix_x      = r_px[X_W-1:0];
    assign pix_y      = r_py[Y_W-1:0];
    // Colour is forced black outside a live pixel so it reads 0 after reset
    assign pix_colour = (r_pv && !r_blank) ? rom_data : COLOUR_BLACK;

endmodule

`default_nettype wire
